adc_ltc1407a_ctrl: RTL and testbench

//   Master-side controller for the LTC1407A-1 dual 14-bit ADC on the SPI bus.
//   On START it pulses AD_CONV, generates one 34-cycle SPI_SCK frame and shifts in ADC_OUT.
//   It then presents both channel results as signed 14-bit words with a one-cycle DONE strobe.
//   It sits between the application (e.g. the amplifier/ADC sampling sequencer) and the ADC pins.

---
 rtl/adc_ltc1407a_ctrl_pkg.sv | 23 ++
 rtl/adc_ltc1407a_ctrl_if.sv | 24 ++
 rtl/adc_ltc1407a_ctrl_spi_sck_div.sv | 52 +++++
 rtl/adc_ltc1407a_ctrl.sv | 110 +++++++++++
 tb/tb_adc_ltc1407a_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_ltc1407a_ctrl_pkg.sv
// Shared constants, FSM encoding and frame helpers for the LTC1407A-1 SPI controller.
package adc_ltc1407a_ctrl_pkg;

  localparam int ADC_BITS    = 14;
  localparam int FRAME_SCK   = 34;
  localparam int CH0_MSB_IDX = 2;
  localparam int CH1_MSB_IDX = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  typedef logic signed [ADC_BITS-1:0] sample_t;

  // True when SCK period k carries a data bit of the channel whose MSB sits at msb_idx.
  function automatic logic in_window(input logic [5:0] k, input int msb_idx);
    return (int'(k) >= msb_idx) && (int'(k) < msb_idx + ADC_BITS);
  endfunction

endpackage

// File: rtl/adc_ltc1407a_ctrl_if.sv
// Application handshake plus ADC pin bundle; the controller is the bus master.
interface adc_ltc1407a_ctrl_if;
  import adc_ltc1407a_ctrl_pkg::*;

  logic    start;
  logic    busy;
  logic    done;
  sample_t ch0;
  sample_t ch1;
  logic    spi_sck;
  logic    ad_conv;
  logic    adc_out;

  modport master (
    input  start, adc_out,
    output busy, done, ch0, ch1, spi_sck, ad_conv
  );

  modport slave (
    output start, adc_out,
    input  busy, done, ch0, ch1, spi_sck, ad_conv
  );

endinterface

// File: rtl/adc_ltc1407a_ctrl_spi_sck_div.sv
// SPI clock divider: CLK_DIV cycles low then CLK_DIV cycles high while enabled, parked low otherwise.
module adc_ltc1407a_ctrl_spi_sck_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_next_o,
  output logic fall_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             last;

  assign last = (cnt_q == CNT_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o       = sck_q;
  assign rise_next_o = en_i & last & ~sck_q;
  assign fall_o      = en_i & last & sck_q;

endmodule

// File: rtl/adc_ltc1407a_ctrl.sv
// LTC1407A-1 master: AD_CONV pulse, one 34-period SCK frame, two signed 14-bit results with DONE.
module adc_ltc1407a_ctrl
  import adc_ltc1407a_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int LOGLEVEL = 5
) (
  input logic                 clk_i,
  input logic                 rst_i,
  adc_ltc1407a_ctrl_if.master bus
);

  if (CLK_DIV < 1 || LOGLEVEL < 0) begin : g_param_check
    $error("adc_ltc1407a_ctrl: CLK_DIV must be >= 1 and LOGLEVEL >= 0");
  end

  localparam int CONV_W = $clog2(2 * CLK_DIV);
  localparam logic [CONV_W-1:0] CONV_LAST   = CONV_W'(2 * CLK_DIV - 1);
  localparam logic [5:0]        PERIOD_LAST = 6'(FRAME_SCK - 1);

  state_e            state_q, state_d;
  logic [CONV_W-1:0] conv_q, conv_d;
  logic [5:0]        period_q, period_d;
  sample_t           sr0_q, sr0_d, sr1_q, sr1_d;
  sample_t           ch0_q, ch0_d, ch1_q, ch1_d;
  logic              busy_q, busy_d, done_q, done_d, ad_conv_q, ad_conv_d;
  logic              sck, rise_next, fall_edge;

  adc_ltc1407a_ctrl_spi_sck_div #(.CLK_DIV(CLK_DIV)) u_sck_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (state_q == ST_SHIFT),
    .sck_o       (sck),
    .rise_next_o (rise_next),
    .fall_o      (fall_edge)
  );

  always_comb begin
    state_d  = state_q;
    conv_d   = conv_q;
    period_d = period_q;
    sr0_d    = sr0_q;
    sr1_d    = sr1_q;
    ch0_d    = ch0_q;
    ch1_d    = ch1_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d  = ST_CONV;
        conv_d   = '0;
        period_d = '0;
      end
      ST_CONV: if (conv_q == CONV_LAST) state_d = ST_SHIFT;
               else conv_d = conv_q + CONV_W'(1);
      ST_SHIFT: begin
        // ADC_OUT is captured on the CLK edge that raises SCK.
        if (rise_next && in_window(period_q, CH0_MSB_IDX)) sr0_d = {sr0_q[ADC_BITS-2:0], bus.adc_out};
        if (rise_next && in_window(period_q, CH1_MSB_IDX)) sr1_d = {sr1_q[ADC_BITS-2:0], bus.adc_out};
        if (fall_edge) begin
          if (period_q == PERIOD_LAST) begin
            state_d = ST_FIN;
            ch0_d   = sr0_q;
            ch1_d   = sr1_q;
          end else begin
            period_d = period_q + 6'd1;
          end
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FIN);
    ad_conv_d = (state_d == ST_CONV);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      conv_q    <= '0;
      period_q  <= '0;
      sr0_q     <= '0;
      sr1_q     <= '0;
      ch0_q     <= '0;
      ch1_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ad_conv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      conv_q    <= conv_d;
      period_q  <= period_d;
      sr0_q     <= sr0_d;
      sr1_q     <= sr1_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ad_conv_q <= ad_conv_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ch0     = ch0_q;
  assign bus.ch1     = ch1_q;
  assign bus.spi_sck = sck;
  assign bus.ad_conv = ad_conv_q;

endmodule

// File: tb/tb_adc_ltc1407a_ctrl.sv
// Directed bench for adc_ltc1407a_ctrl: D=2 instance with a serial ADC model, D=1 instance for throughput.
module tb_adc_ltc1407a_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_ltc1407a_ctrl_if bus2();
  adc_ltc1407a_ctrl_if bus1();

  adc_ltc1407a_ctrl #(.CLK_DIV(2), .LOGLEVEL(0)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
  adc_ltc1407a_ctrl #(.CLK_DIV(1), .LOGLEVEL(0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  // Serial ADC model for dut2: bit k of adc_frame is presented during SCK period k.
  logic [33:0] adc_frame = '0;
  int          adc_idx = 0;
  logic        m_sck_prev = 1'b0;

  always @(negedge clk) begin
    if (bus2.ad_conv) adc_idx = 0;
    else if (m_sck_prev && !bus2.spi_sck) adc_idx = adc_idx + 1;
    m_sck_prev = bus2.spi_sck;
    bus2.adc_out = (adc_idx < 34) ? adc_frame[6'(adc_idx)] : 1'b0;
  end

  function automatic logic [33:0] build_frame(input logic [13:0] c0, input logic [13:0] c1, input logic ign);
    logic [33:0] f;
    for (int k = 0; k < 34; k++) begin
      if (k >= 2 && k <= 15)       f[k] = c0[15-k];
      else if (k >= 18 && k <= 31) f[k] = c1[31-k];
      else                         f[k] = ign;
    end
    return f;
  endfunction

  function automatic logic [33:0] toggle_frame();
    logic [33:0] f;
    for (int k = 0; k < 34; k++) f[k] = k[0];
    return f;
  endfunction

  // Per-frame observations of dut2, relative to the START cycle.
  int          done_cnt, done_cyc, sck_rises, conv_first, conv_last, conv_cnt;
  logic        busy_at1, busy_after_done, sck_after_rst, busy_after_rst;
  logic [13:0] ch0_at_done, ch1_at_done;

  task automatic run_frame(input int extra_start_at, input int rst_at, input int ncyc);
    int   t0, rel;
    logic sck_prev;
    done_cnt = 0; done_cyc = -10; sck_rises = 0;
    conv_first = -1; conv_last = -1; conv_cnt = 0;
    busy_at1 = 1'bx; busy_after_done = 1'bx; sck_after_rst = 1'bx; busy_after_rst = 1'bx;
    ch0_at_done = 'x; ch1_at_done = 'x;
    sck_prev = 1'b0;
    @(negedge clk);
    t0 = cyc;
    bus2.start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (bus2.spi_sck && !sck_prev) sck_rises++;
      sck_prev = bus2.spi_sck;
      if (bus2.ad_conv) begin
        if (conv_first < 0) conv_first = rel;
        conv_last = rel;
        conv_cnt++;
      end
      if (rel == 1) busy_at1 = bus2.busy;
      if (rel == done_cyc + 1) busy_after_done = bus2.busy;
      if (bus2.done) begin
        done_cnt++;
        done_cyc = rel;
        ch0_at_done = bus2.ch0;
        ch1_at_done = bus2.ch1;
      end
      if (rel == rst_at + 1) begin
        sck_after_rst  = bus2.spi_sck;
        busy_after_rst = bus2.busy;
      end
      bus2.start = (rel == extra_start_at);
      rst        = (rel == rst_at);
    end
    bus2.start = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    logic prev;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (bus2.spi_sck !== 1'b0) begin n_miss++; $display("FAIL reset_sck got=%b exp=0", bus2.spi_sck); end
    n_vec++; if (bus2.ad_conv !== 1'b0) begin n_miss++; $display("FAIL reset_ad_conv got=%b exp=0", bus2.ad_conv); end
    n_vec++; if (bus2.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got=%b exp=0", bus2.busy); end
    n_vec++; if (bus2.done !== 1'b0) begin n_miss++; $display("FAIL reset_done got=%b exp=0", bus2.done); end
    n_vec++; if (bus2.ch0 !== 14'h0 || bus2.ch1 !== 14'h0) begin
      n_miss++; $display("FAIL reset_ch got=%h/%h exp=0000/0000", bus2.ch0, bus2.ch1);
    end
    edges = 0;
    prev  = bus2.spi_sck;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus2.spi_sck !== prev) edges++;
      prev = bus2.spi_sck;
    end
    n_vec++; if (edges !== 0) begin n_miss++; $display("FAIL idle_sck_edges got=%0d exp=0", edges); end
  endtask

  task automatic test_toggle_frame();
    adc_frame = toggle_frame();
    run_frame(-1, -1, 200);
    n_vec++; if (conv_first !== 1) begin n_miss++; $display("FAIL conv_first got=%0d exp=1", conv_first); end
    n_vec++; if (conv_last !== 4) begin n_miss++; $display("FAIL conv_last got=%0d exp=4", conv_last); end
    n_vec++; if (conv_cnt !== 4) begin n_miss++; $display("FAIL conv_cycles got=%0d exp=4", conv_cnt); end
    n_vec++; if (sck_rises !== 34) begin n_miss++; $display("FAIL sck_rises got=%0d exp=34", sck_rises); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL done_count got=%0d exp=1", done_cnt); end
    n_vec++; if (done_cyc !== 141) begin n_miss++; $display("FAIL done_latency got=%0d exp=141", done_cyc); end
    n_vec++; if (ch0_at_done !== 14'h1555) begin n_miss++; $display("FAIL toggle_ch0 got=%h exp=1555", ch0_at_done); end
    n_vec++; if (ch1_at_done !== 14'h1555) begin n_miss++; $display("FAIL toggle_ch1 got=%h exp=1555", ch1_at_done); end
    n_vec++; if (busy_at1 !== 1'b1) begin n_miss++; $display("FAIL busy_cycle1 got=%b exp=1", busy_at1); end
    n_vec++; if (busy_after_done !== 1'b0) begin n_miss++; $display("FAIL busy_after_done got=%b exp=0", busy_after_done); end
  endtask

  task automatic test_full_scale();
    adc_frame = build_frame(14'h1FFF, 14'h2000, 1'b1);
    run_frame(-1, -1, 200);
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL fs_done_count got=%0d exp=1", done_cnt); end
    n_vec++; if (int'($signed(ch0_at_done)) !== 8191) begin
      n_miss++; $display("FAIL fs_ch0 got=%0d exp=8191", $signed(ch0_at_done));
    end
    n_vec++; if (int'($signed(ch1_at_done)) !== -8192) begin
      n_miss++; $display("FAIL fs_ch1 got=%0d exp=-8192", $signed(ch1_at_done));
    end
  endtask

  task automatic test_restart_ignored();
    // SCK period 10 starts at 2D+1+2D*10 = 45 for D=2.
    adc_frame = toggle_frame();
    run_frame(45, -1, 350);
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
    n_vec++; if (sck_rises !== 34) begin n_miss++; $display("FAIL restart_sck_rises got=%0d exp=34", sck_rises); end
    n_vec++; if (done_cyc !== 141) begin n_miss++; $display("FAIL restart_done_latency got=%0d exp=141", done_cyc); end
  endtask

  task automatic test_abort();
    // Period 20 high phase is cycles 87..88 for D=2; reset is sampled at the edge ending cycle 87.
    adc_frame = toggle_frame();
    run_frame(-1, 87, 300);
    n_vec++; if (sck_after_rst !== 1'b0) begin n_miss++; $display("FAIL abort_sck got=%b exp=0", sck_after_rst); end
    n_vec++; if (busy_after_rst !== 1'b0) begin n_miss++; $display("FAIL abort_busy got=%b exp=0", busy_after_rst); end
    n_vec++; if (done_cnt !== 0) begin n_miss++; $display("FAIL abort_done_count got=%0d exp=0", done_cnt); end
    n_vec++; if (bus2.ch0 !== 14'h0 || bus2.ch1 !== 14'h0) begin
      n_miss++; $display("FAIL abort_ch got=%h/%h exp=0000/0000", bus2.ch0, bus2.ch1);
    end
  endtask

  task automatic test_back_to_back();
    int   dq[$];
    int   cq[$];
    int   exp_done[3] = '{71, 143, 215};
    int   t0, rel, got;
    logic conv_prev;
    conv_prev = 1'b0;
    @(negedge clk);
    t0 = cyc;
    bus1.start = 1'b1;
    for (int i = 0; i < 230; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (bus1.done) dq.push_back(rel);
      if (bus1.ad_conv && !conv_prev) cq.push_back(rel);
      conv_prev = bus1.ad_conv;
    end
    bus1.start = 1'b0;
    n_vec++; if (dq.size() !== 3) begin n_miss++; $display("FAIL b2b_done_count got=%0d exp=3", dq.size()); end
    for (int j = 0; j < 3; j++) begin
      got = (j < dq.size()) ? dq[j] : -1;
      n_vec++; if (got !== exp_done[j]) begin n_miss++; $display("FAIL b2b_done%0d got=%0d exp=%0d", j, got, exp_done[j]); end
    end
    for (int j = 1; j < 3; j++) begin
      got = (j < cq.size()) ? cq[j] - cq[j-1] : -1;
      n_vec++; if (got !== 72) begin n_miss++; $display("FAIL b2b_conv_spacing%0d got=%0d exp=72", j, got); end
    end
  endtask

  initial begin
    bus2.start = 1'b0;
    bus1.start = 1'b0;
    bus1.adc_out = 1'b0;
    test_reset();
    test_toggle_frame();
    test_full_scale();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
